// File: rtl/and_gate_vector_sequencer.sv
// Purpose: steps a 3-input AND gate through every input vector and checks its output.
// Latency: done pulses 2^N_IN*HOLD_CYCLES cycles after the edge that accepts start.
// Backpressure: none; start is honoured only in IDLE and is dropped otherwise.
// Optional: define FIRST_ERR_CAPTURE_EN to add first_err_vld/first_err_vec.
module and_gate_vector_sequencer #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_dout,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic             first_err_vld,
  output logic [N_IN-1:0]  first_err_vec
`endif
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HC_W-1:0]   hold_cnt;
  logic              sample;
  logic              last_vec;
  logic              mismatch;
  logic              err_sat;

  // Sample happens on the final hold cycle of each vector; the all-ones vector ends the run.
  assign sample   = (state == DRIVE) && (hold_cnt == HC_W'(HOLD_CYCLES - 1));
  assign last_vec = &vec_out;
  assign mismatch = sample && (dut_dout != (&vec_out));
  assign err_sat  = &err_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode; busy/done follow the state directly.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (sample && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stimulus counters and result bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out  <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vec_out  <= '0;
          hold_cnt <= '0;
          if (start) begin
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          if (!sample) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            if (mismatch && !err_sat) err_cnt <= err_cnt + 1'b1;
            if (last_vec) begin
              pass <= (err_cnt == '0) && !mismatch;
            end else begin
              vec_out  <= vec_out + 1'b1;
              hold_cnt <= '0;
            end
          end
        end
        DONE: begin
          vec_out  <= '0;
          hold_cnt <= '0;
        end
        default: begin
          vec_out  <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  // Latch the vector of the first mismatch in a run; cleared when a run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
    end else if (state == IDLE && start) begin
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_vec <= vec_out;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate_vector_sequencer.sv
module tb_and_gate_vector_sequencer;

  localparam int HOLD  = 4;
  localparam int NVEC  = 8;
  localparam int RUN_C = NVEC * HOLD;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_dout;
  logic [2:0] vec_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;

  logic       start2;
  logic       dut_dout2;
  logic [2:0] vec_out2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [1:0] err_cnt2;

`ifdef FIRST_ERR_CAPTURE_EN
  logic       first_err_vld;
  logic [2:0] first_err_vec;
  logic       first_err_vld2;
  logic [2:0] first_err_vec2;
`endif

  // Gate model: bit v of fault_mask makes the gate answer wrongly for input vector v.
  logic [7:0] fault_mask;

  int checks;
  int errors;

  assign dut_dout  = (&vec_out) ^ fault_mask[vec_out];
  assign dut_dout2 = ~(&vec_out2);

  and_gate_vector_sequencer #(.N_IN(3), .HOLD_CYCLES(HOLD), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_dout(dut_dout),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_vec(first_err_vec)
`endif
  );

  and_gate_vector_sequencer #(.N_IN(3), .HOLD_CYCLES(HOLD), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_dout(dut_dout2),
    .vec_out(vec_out2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld2), .first_err_vec(first_err_vec2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcount8(input logic [7:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_out, busy, done, pass, err_cnt} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d, want all 0",
               vec_out, busy, done, pass, err_cnt);
    end
`ifdef FIRST_ERR_CAPTURE_EN
    checks++;
    if ({first_err_vld, first_err_vec} !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_err: got vld=%0b vec=%0d, want 0", first_err_vld, first_err_vec);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (vec_out !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got vec=%0d busy=%0b, want 0 0", vec_out, busy);
    end
  endtask

  // Caller is at a negedge. Launches a run, checks every cycle of it, the DONE cycle and the
  // following IDLE cycle. restart_at: drive cycle in which start is re-pulsed (-1 none).
  task automatic do_run(input logic [7:0] mask, input int restart_at, input bit pulse_in_done,
                        input string name);
    int         exp_err;
    logic       exp_pass;
    logic [2:0] exp_vec;
    exp_err  = popcount8(mask);
    if (exp_err > 15) exp_err = 15;
    exp_pass = (mask == 8'd0);
    fault_mask = mask;
    start = 1'b1;
    for (int k = 0; k < RUN_C; k++) begin
      @(negedge clk);
      start   = (k == restart_at);
      exp_vec = 3'(k / HOLD);
      checks++;
      if (vec_out !== exp_vec || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s drive_cyc%0d: got vec=%0d busy=%0b done=%0b, want vec=%0d busy=1 done=0",
                 name, k, vec_out, busy, done, exp_vec);
      end
      if (k == 0) begin
        checks++;
        if (err_cnt !== 4'd0 || pass !== 1'b0) begin
          errors++;
          $display("FAIL %s start_clear: got err=%0d pass=%0b, want 0 0", name, err_cnt, pass);
        end
      end
    end
    @(negedge clk);
    start = pulse_in_done;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 4'(exp_err) || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%0b busy=%0b err=%0d pass=%0b, want 1 0 %0d %0b",
               name, done, busy, err_cnt, pass, exp_err, exp_pass);
    end
`ifdef FIRST_ERR_CAPTURE_EN
    checks++;
    if (first_err_vld !== (mask != 8'd0) ||
        (mask != 8'd0 && first_err_vec !== lowest_set(mask))) begin
      errors++;
      $display("FAIL %s first_err: got vld=%0b vec=%0d, want vld=%0b vec=%0d",
               name, first_err_vld, first_err_vec, (mask != 8'd0), lowest_set(mask));
    end
`endif
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || vec_out !== 3'd0 ||
        err_cnt !== 4'(exp_err) || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b busy=%0b vec=%0d err=%0d pass=%0b, want 0 0 0 %0d %0b",
               name, done, busy, vec_out, err_cnt, pass, exp_err, exp_pass);
    end
  endtask

  task automatic test_good_gate();
    do_run(8'h00, -1, 1'b0, "good_gate");
  endtask

  task automatic test_stuck0();
    do_run(8'h80, -1, 1'b0, "stuck0");
  endtask

  task automatic test_stuck1();
    do_run(8'h7F, -1, 1'b0, "stuck1");
  endtask

  // Re-pulses during DRIVE and DONE must be dropped; the start right after DONE is taken
  // and must clear the previous run's results (checked at the start of the second run).
  task automatic test_start_ignored();
    do_run(8'h15, 10, 1'b1, "restart_ignored");
    do_run(8'h00, -1, 1'b0, "restart_accepted");
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    saw_done = 1'b0;
    fault_mask = 8'h01;
    start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_out, busy, done, pass, err_cnt} !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d, want all 0",
               vec_out, busy, done, pass, err_cnt);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (RUN_C) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got done pulse=%0b, want 0", saw_done);
    end
    do_run(8'h00, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int r = 0; r < 6; r++) begin
      m = 8'($urandom_range(0, 255));
      if (r == 0) m = 8'hFF;
      do_run(m, -1, 1'b0, $sformatf("random%0d", r));
    end
  endtask

  task automatic test_saturate();
    int  cyc;
    bit  got;
    got = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!got && cyc < 100) begin
      if (done2) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!got || cyc != RUN_C + 1) begin
      errors++;
      $display("FAIL sat_done_latency: got done=%0b at cycle %0d, want done at %0d",
               got, cyc, RUN_C + 1);
    end
    checks++;
    if (err_cnt2 !== 2'd3 || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_err_cnt: got err=%0d pass=%0b, want 3 0", err_cnt2, pass2);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    start      = 1'b0;
    start2     = 1'b0;
    fault_mask = 8'h00;
    rst_n      = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_gate();
    test_stuck0();
    test_stuck1();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
